// File: rtl/cpu2core_cpu_0_cpu_debug_mon_master_if.sv
// cpu2core_cpu_0_cpu_debug_mon_master_if: Avalon-style single-word master bus into the debug/monitor memory
interface cpu2core_cpu_0_cpu_debug_mon_master_if;
    logic [10:0] mon_address;
    logic        mon_read;
    logic        mon_write;
    logic [31:0] mon_writedata;
    logic [3:0]  mon_byteenable;
    logic [31:0] mon_readdata;
    logic        mon_waitrequest;
    modport master (
        output mon_address, mon_read, mon_write, mon_writedata, mon_byteenable,
        input  mon_readdata, mon_waitrequest
    );
    modport slave (
        input  mon_address, mon_read, mon_write, mon_writedata, mon_byteenable,
        output mon_readdata, mon_waitrequest
    );
endinterface

// File: rtl/cpu2core_cpu_0_cpu_debug_mon_master.sv
// cpu2core_cpu_0_cpu_debug_mon_master: turns ocimem debug strobes into single-word monitor bus reads/writes
module cpu2core_cpu_0_cpu_debug_mon_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_no_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        debugack,
    cpu2core_cpu_0_cpu_debug_mon_master_if.master mon,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    state_t      state, state_d;
    logic [8:0]  mon_a_reg, a_d;
    logic [31:0] d_d;
    logic        rdy_d, err_d;
    logic [7:0]  cnt, cnt_d;
    logic        go_a, go_b, go_n, any, lose, want;
    logic        unused;
    assign unused = ^{jdo[37:35], jdo[2:0]};
    assign go_a = take_action_ocimem_a;
    assign go_b = !go_a && take_action_ocimem_b;
    assign go_n = !go_a && !take_action_ocimem_b && take_no_action_ocimem_a;
    assign any  = take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a;
    assign lose = (take_action_ocimem_a && take_action_ocimem_b) ||
                  ((take_action_ocimem_a || take_action_ocimem_b) && take_no_action_ocimem_a);
    assign want = (go_a && jdo[34]) || go_b || go_n;
    // bus requests decode straight from the state register, so no strobe reaches the bus combinationally
    assign mon.mon_address    = {mon_a_reg, 2'b00};
    assign mon.mon_read       = state == RD;
    assign mon.mon_write      = state == WR;
    assign mon.mon_writedata  = MonDReg;
    assign mon.mon_byteenable = 4'hF;
    always_comb begin
        state_d = state;
        a_d     = mon_a_reg;
        d_d     = MonDReg;
        rdy_d   = monitor_ready;
        err_d   = monitor_error;
        cnt_d   = cnt;
        if (state == IDLE) begin
            if (any) begin
                rdy_d = 1'b0;
                err_d = lose;
                if (go_a) a_d = jdo[25:17];
                if (go_b) d_d = jdo[34:3];
                if (go_a && !jdo[34]) rdy_d = 1'b1;
                if (want && !debugack) begin
                    rdy_d = 1'b1;
                    err_d = 1'b1;
                end else if (want) begin
                    state_d = go_b ? WR : RD;
                end
            end
        end else begin
            if (any) err_d = 1'b1;
            if (!mon.mon_waitrequest) begin
                state_d = IDLE;
                rdy_d   = 1'b1;
                a_d     = mon_a_reg + 9'd1;
                cnt_d   = 8'd0;
                if (state == RD) d_d = mon.mon_readdata;
            end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                rdy_d   = 1'b1;
                err_d   = 1'b1;
                cnt_d   = 8'd0;
            end else begin
                cnt_d = cnt + 8'd1;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            mon_a_reg     <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            cnt           <= '0;
        end else begin
            state         <= state_d;
            mon_a_reg     <= a_d;
            MonDReg       <= d_d;
            monitor_ready <= rdy_d;
            monitor_error <= err_d;
            cnt           <= cnt_d;
        end
    end
endmodule

// File: tb/tb_cpu2core_cpu_0_cpu_debug_mon_master.sv
// tb_cpu2core_cpu_0_cpu_debug_mon_master: cycle-level check of the monitor master against a command-level model
module tb_cpu2core_cpu_0_cpu_debug_mon_master;
    localparam int T = 8;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        sa = 1'b0, sn = 1'b0, sb = 1'b0;
    logic        debugack = 1'b1;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;
    logic [31:0] rd_val = '0;
    int          waits = 0;
    int          wcnt;
    int          vectors = 0, errors = 0;
    int unsigned m_addr = 0;
    logic [31:0] m_data = '0;

    cpu2core_cpu_0_cpu_debug_mon_master_if mon();

    cpu2core_cpu_0_cpu_debug_mon_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(sa), .take_no_action_ocimem_a(sn), .take_action_ocimem_b(sb),
        .debugack(debugack), .mon(mon),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
    );

    always #5 clk = ~clk;

    // slave: stalls the first `waits` cycles of each request
    assign mon.mon_waitrequest = (mon.mon_read || mon.mon_write) && wcnt < waits;
    assign mon.mon_readdata    = rd_val;
    always @(posedge clk or negedge reset_n)
        if (!reset_n) wcnt <= 0;
        else wcnt <= ((mon.mon_read || mon.mon_write) && mon.mon_waitrequest) ? wcnt + 1 : 0;

    function automatic logic [37:0] mk_a(input bit rd, input logic [8:0] addr);
        logic [37:0] j;
        j = '0;
        j[34] = rd;
        j[25:17] = addr;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    // Issue one strobe set in cycle N and check every cycle N+1..N+lat+1 against the command-level outcome
    task automatic do_cmd(input bit a, input bit n, input bit b, input logic [37:0] j,
                          input bit ack, input int w, input int poke);
        bit rd, wr, ok, to, lose, ferr;
        int hold, lat;
        int unsigned old_a, new_a;
        logic [31:0] pre_d, post_d, ed;
        logic [10:0] ea;
        rd = 0; wr = 0;
        lose = (int'(a) + int'(n) + int'(b)) > 1;
        old_a = m_addr;
        pre_d = m_data;
        if (a) begin
            old_a = int'(j[25:17]);
            rd = j[34];
        end else if (b) begin
            wr = 1;
            pre_d = j[34:3];
        end else begin
            rd = 1;
        end
        ok   = (rd || wr) && ack;
        to   = ok && w >= T;
        hold = !ok ? 0 : to ? T : w + 1;
        lat  = hold + 1;
        if (poke > hold) poke = 0;
        new_a  = old_a;
        post_d = pre_d;
        ferr   = lose || ((rd || wr) && !ack) || to || poke > 0;
        if (ok && !to) begin
            new_a = (old_a + 1) % 512;
            if (rd) post_d = rd_val;
        end
        waits = w; debugack = ack; jdo = j; sa = a; sn = n; sb = b;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            sa = 0; sn = 0; sb = 0;
            ea = 11'(((c <= hold) ? old_a : new_a) * 4);
            ed = (c < lat) ? pre_d : post_d;
            vectors += 7;
            if (mon.mon_read !== (rd && c <= hold)) begin
                errors++; $display("FAIL mon_read c=%0d got %b exp %b", c, mon.mon_read, rd && c <= hold);
            end
            if (mon.mon_write !== (wr && c <= hold)) begin
                errors++; $display("FAIL mon_write c=%0d got %b exp %b", c, mon.mon_write, wr && c <= hold);
            end
            if (mon.mon_address !== ea) begin
                errors++; $display("FAIL mon_address c=%0d got %h exp %h", c, mon.mon_address, ea);
            end
            if (MonDReg !== ed) begin
                errors++; $display("FAIL MonDReg c=%0d got %h exp %h", c, MonDReg, ed);
            end
            if (mon.mon_writedata !== ed || mon.mon_byteenable !== 4'hF) begin
                errors++; $display("FAIL writedata/be c=%0d got %h/%h exp %h/f", c, mon.mon_writedata, mon.mon_byteenable, ed);
            end
            if (monitor_ready !== (c >= lat)) begin
                errors++; $display("FAIL ready c=%0d got %b exp %b", c, monitor_ready, c >= lat);
            end
            if (monitor_error !== ((c >= lat) ? ferr : (lose || (poke > 0 && c > poke)))) begin
                errors++; $display("FAIL error c=%0d got %b exp %b", c, monitor_error,
                                   (c >= lat) ? ferr : (lose || (poke > 0 && c > poke)));
            end
            if (c == poke) sn = 1;
        end
        m_addr = new_a;
        m_data = post_d;
    endtask

    task automatic test_reset;
        reset_n = 0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({mon.mon_read, mon.mon_write, mon.mon_address, MonDReg, monitor_ready, monitor_error} !== '0) begin
            errors++; $display("FAIL reset_state got %b/%b/%h/%h/%b/%b exp all zero", mon.mon_read, mon.mon_write,
                               mon.mon_address, MonDReg, monitor_ready, monitor_error);
        end
        reset_n = 1;
        m_addr = 0; m_data = '0;
        @(negedge clk);
    endtask

    task automatic test_plan_read;
        rd_val = 32'hDEADBEEF;
        do_cmd(1, 0, 0, mk_a(1, 9'h004), 1, 0, 0);
    endtask

    task automatic test_plan_write;
        do_cmd(0, 0, 1, mk_b(32'h12345678), 1, 3, 0);
    endtask

    task automatic test_wrap;
        do_cmd(1, 0, 0, mk_a(0, 9'h1FF), 1, 0, 0);
        rd_val = 32'hA5A5_0F0F;
        do_cmd(0, 1, 0, '0, 1, 1, 0);
    endtask

    task automatic test_debugack;
        do_cmd(0, 0, 1, mk_b(32'hCAFE_F00D), 0, 0, 0);
        do_cmd(1, 0, 0, mk_a(1, 9'h0AA), 0, 0, 0);
    endtask

    task automatic test_timeout;
        do_cmd(0, 1, 0, '0, 1, 50, 0);
        do_cmd(0, 0, 1, mk_b(32'h0BAD_0BAD), 1, T - 1, 0);
    endtask

    task automatic test_collision;
        rd_val = 32'h1357_9BDF;
        do_cmd(1, 0, 1, mk_a(1, 9'h020), 1, 0, 0);
        rd_val = 32'h2468_ACE0;
        do_cmd(0, 1, 0, '0, 1, 2, 1);
        do_cmd(0, 1, 0, '0, 1, 0, 0);
    endtask

    task automatic test_reset_mid;
        waits = 50;
        sn = 1;
        @(negedge clk);
        sn = 0;
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        vectors++;
        if ({mon.mon_read, mon.mon_address, MonDReg, monitor_ready, monitor_error} !== '0) begin
            errors++; $display("FAIL async_reset got %b/%h/%h/%b/%b exp all zero", mon.mon_read, mon.mon_address,
                               MonDReg, monitor_ready, monitor_error);
        end
        @(negedge clk);
        reset_n = 1;
        m_addr = 0; m_data = '0;
        @(negedge clk);
    endtask

    task automatic test_random;
        bit a, n, b;
        int w;
        for (int i = 0; i < 60; i++) begin
            {a, n, b} = 3'($urandom_range(1, 7));
            w = ($urandom_range(0, 9) == 0) ? T + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
            rd_val = $urandom;
            do_cmd(a, n, b, {6'($urandom), 32'($urandom)}, $urandom_range(0, 4) != 0, w,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end
    endtask

    initial begin
        test_reset;
        test_plan_read;
        test_plan_write;
        test_wrap;
        test_debugack;
        test_timeout;
        test_collision;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
